// File: rtl/nv_nvdla_cdp_dp_out_cvt.sv
// CDP output converter: per-lane offset subtract, scale multiply, rounded right shift and
// saturation to OW bits, as a three-stage valid/ready pipeline with a saturated-lane counter.
module nv_nvdla_cdp_dp_out_cvt #(
  parameter int unsigned THROUGHPUT = 4,
  parameter int unsigned ICVTO_BWPE = 9,
  parameter int unsigned OW         = 8
) (
  input  logic                                       nvdla_core_clk,
  input  logic                                       nvdla_core_rstn,
  input  logic [THROUGHPUT*(ICVTO_BWPE+16)-1:0]      mul2ocvt_pd,
  input  logic                                       mul2ocvt_pvld,
  output logic                                       mul2ocvt_prdy,
  input  logic [15:0]                                reg2dp_datout_offset,
  input  logic [15:0]                                reg2dp_datout_scale,
  input  logic [5:0]                                 reg2dp_datout_shifter,
  input  logic                                       reg2dp_sat_clr,
  output logic [THROUGHPUT*OW-1:0]                   cvtout_pd,
  output logic                                       cvtout_pvld,
  input  logic                                       cvtout_prdy,
  output logic [31:0]                                dp2reg_out_saturation
);

  localparam int unsigned IW = ICVTO_BWPE + 16;
  localparam int unsigned DW = IW + 1;
  localparam int unsigned PW = IW + 17;
  // One guard bit so the rounding constant cannot overflow the product.
  localparam int unsigned RW = PW + 1;
  localparam int unsigned CW = $clog2(THROUGHPUT + 1);
  localparam logic signed [RW-1:0] SatMax = RW'((1 << (OW - 1)) - 1);
  localparam logic signed [RW-1:0] SatMin = ~SatMax;

  logic signed [15:0]           r_offset;
  logic signed [15:0]           r_scale;
  logic [5:0]                   r_shift;
  logic                         r_s1_vld, r_s2_vld, r_s3_vld;
  logic [THROUGHPUT*DW-1:0]     r_s1_diff;
  logic [THROUGHPUT*PW-1:0]     r_s2_prod;
  logic [THROUGHPUT*OW-1:0]     r_s3_pd;
  logic [CW-1:0]                r_s3_nsat;
  logic [31:0]                  r_sat_cnt;

  logic                         w_s1_rdy, w_s2_rdy, w_s3_rdy;
  logic                         w_s1_ld, w_s2_ld, w_s3_ld, w_out_xfer;
  logic [THROUGHPUT*DW-1:0]     w_s1_diff;
  logic [THROUGHPUT*PW-1:0]     w_s2_prod;
  logic [THROUGHPUT*OW-1:0]     w_s3_pd;
  logic [CW-1:0]                w_s3_nsat;
  logic signed [DW-1:0]         w_diff_tmp;
  logic signed [PW-1:0]         w_prod_tmp;
  logic signed [RW-1:0]         w_rnd_tmp;
  logic signed [RW-1:0]         w_sh_tmp;
  logic [32:0]                  w_cnt_sum;

  assign w_s3_rdy   = !r_s3_vld || cvtout_prdy;
  assign w_s2_rdy   = !r_s2_vld || w_s3_rdy;
  assign w_s1_rdy   = !r_s1_vld || w_s2_rdy;
  assign w_s1_ld    = mul2ocvt_pvld && w_s1_rdy;
  assign w_s2_ld    = r_s1_vld && w_s2_rdy;
  assign w_s3_ld    = r_s2_vld && w_s3_rdy;
  assign w_out_xfer = r_s3_vld && cvtout_prdy;

  assign mul2ocvt_prdy         = w_s1_rdy;
  assign cvtout_pvld           = r_s3_vld;
  assign cvtout_pd             = r_s3_pd;
  assign dp2reg_out_saturation = r_sat_cnt;

  always_comb begin
    w_s1_diff  = '0;
    w_s2_prod  = '0;
    w_s3_pd    = '0;
    w_s3_nsat  = '0;
    w_diff_tmp = '0;
    w_prod_tmp = '0;
    w_rnd_tmp  = '0;
    w_sh_tmp   = '0;
    for (int m = 0; m < THROUGHPUT; m++) begin
      w_diff_tmp = DW'($signed(mul2ocvt_pd[m*IW +: IW])) - DW'(r_offset);
      w_s1_diff[m*DW +: DW] = w_diff_tmp;

      w_prod_tmp = PW'($signed(r_s1_diff[m*DW +: DW])) * PW'(r_scale);
      w_s2_prod[m*PW +: PW] = w_prod_tmp;

      w_rnd_tmp = RW'($signed(r_s2_prod[m*PW +: PW]));
      if (r_shift == 6'd0) begin
        w_sh_tmp = w_rnd_tmp;
      end else if (32'(r_shift) > PW) begin
        // Shifts wider than the product always round to zero.
        w_sh_tmp = '0;
      end else begin
        w_sh_tmp = (w_rnd_tmp + (RW'(1) << (r_shift - 6'd1))) >>> r_shift;
      end

      if (w_sh_tmp > SatMax) begin
        w_s3_pd[m*OW +: OW] = SatMax[OW-1:0];
        w_s3_nsat           = w_s3_nsat + CW'(1);
      end else if (w_sh_tmp < SatMin) begin
        w_s3_pd[m*OW +: OW] = SatMin[OW-1:0];
        w_s3_nsat           = w_s3_nsat + CW'(1);
      end else begin
        w_s3_pd[m*OW +: OW] = w_sh_tmp[OW-1:0];
      end
    end
  end

  assign w_cnt_sum = {1'b0, r_sat_cnt} + 33'(r_s3_nsat);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_offset  <= '0;
      r_scale   <= '0;
      r_shift   <= '0;
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s3_vld  <= 1'b0;
      r_s1_diff <= '0;
      r_s2_prod <= '0;
      r_s3_pd   <= '0;
      r_s3_nsat <= '0;
      r_sat_cnt <= '0;
    end else begin
      r_offset <= reg2dp_datout_offset;
      r_scale  <= reg2dp_datout_scale;
      r_shift  <= reg2dp_datout_shifter;
      if (w_s1_rdy) r_s1_vld <= mul2ocvt_pvld;
      if (w_s2_rdy) r_s2_vld <= r_s1_vld;
      if (w_s3_rdy) r_s3_vld <= r_s2_vld;
      if (w_s1_ld) r_s1_diff <= w_s1_diff;
      if (w_s2_ld) r_s2_prod <= w_s2_prod;
      if (w_s3_ld) begin
        r_s3_pd   <= w_s3_pd;
        r_s3_nsat <= w_s3_nsat;
      end
      if (reg2dp_sat_clr) begin
        r_sat_cnt <= '0;
      end else if (w_out_xfer) begin
        r_sat_cnt <= w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
      end
    end
  end

endmodule

// File: doc/nv_nvdla_cdp_dp_out_cvt.md
NV_NVDLA_CDP_DP_OUT_CVT -- requirements
Module: nv_nvdla_cdp_dp_out_cvt

Interface
REQ-001 Parameter THROUGHPUT, default 4, SHALL be the number of lanes per transfer.
REQ-002 Parameter ICVTO_BWPE, default 9, SHALL be the multiplier input-a width; lane input width IW = ICVTO_BWPE+16.
REQ-003 Parameter OW, default 8, SHALL be the signed output lane width.
REQ-004 nvdla_core_clk  in  1  SHALL be the single clock.
REQ-005 nvdla_core_rstn  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 mul2ocvt_pd  in  THROUGHPUT*IW  SHALL carry the product lanes from the multiplier stage, lane m at bits [m*IW+IW-1:m*IW], signed.
REQ-007 mul2ocvt_pvld  in  1  SHALL be input valid.
REQ-008 mul2ocvt_prdy  out  1  SHALL be input ready.
REQ-009 reg2dp_datout_offset  in  16  SHALL be the signed offset.
REQ-010 reg2dp_datout_scale  in  16  SHALL be the signed scale.
REQ-011 reg2dp_datout_shifter  in  6  SHALL be the unsigned right-shift amount.
REQ-012 reg2dp_sat_clr  in  1  SHALL be the single-cycle clear pulse for the saturation counter.
REQ-013 cvtout_pd  out  THROUGHPUT*OW  SHALL carry the converted lanes, same lane order as the input.
REQ-014 cvtout_pvld  out  1  SHALL be output valid.
REQ-015 cvtout_prdy  in  1  SHALL be output ready.
REQ-016 dp2reg_out_saturation  out  32  SHALL be the saturated-lane count.

Function
REQ-017 The offset, scale and shifter inputs SHALL be registered every cycle, and the datapath SHALL use only these registered copies, giving 1 cycle of config latency.
REQ-018 A transfer SHALL occur on any edge where pvld and prdy are both 1, on both input and output.
REQ-019 The datapath SHALL be a three-stage valid/ready pipeline: S1 diff, S2 product, S3 convert; each stage SHALL hold one valid bit and one data register.
REQ-020 A stage SHALL load when its upstream is valid and it is empty or being drained in the same cycle; mul2ocvt_prdy SHALL equal (S1 empty OR S1 drains this cycle).
REQ-021 S1 SHALL compute diff = lane − sign-extended offset, IW+1 bits, with no overflow.
REQ-022 S2 SHALL compute prod = diff * scale, IW+17 bits signed, exact.
REQ-023 In S3, shift 0 SHALL pass prod unchanged.
REQ-024 In S3, shift s>0 SHALL give (prod + 2^(s−1)) arithmetically shifted right by s, computed without overflow.
REQ-025 The S3 result SHALL saturate to [−2^(OW−1), 2^(OW−1)−1]; a lane is "saturated" when clipping occurs.
REQ-026 Latency from input transfer to cvtout_pvld SHALL be 3 cycles with no backpressure, and full throughput SHALL be one transfer per cycle.
REQ-027 Under backpressure, no word SHALL be dropped, duplicated or reordered, and cvtout_pd SHALL stay stable while cvtout_pvld=1 and cvtout_prdy=0.
REQ-028 On each output transfer, dp2reg_out_saturation SHALL increase by the number of saturated lanes in that word (0..THROUGHPUT).
REQ-029 dp2reg_out_saturation SHALL saturate at 0xFFFFFFFF.
REQ-030 When reg2dp_sat_clr and an output transfer coincide, the counter SHALL become 0 and the increment SHALL be discarded.
REQ-031 Config changes while data is in flight SHALL affect only words entering a stage after the registered copy updates, with no other hazard handling.

Reset
REQ-032 When nvdla_core_rstn is low, all stage valids SHALL be 0, data registers and config copies 0, cvtout_pvld=0, cvtout_pd=0 and dp2reg_out_saturation=0.
REQ-033 A reset asserted mid-operation SHALL discard all in-flight words, and nothing SHALL be emitted after deassertion until new input transfers occur.
REQ-034 mul2ocvt_prdy SHALL be 1 in the first cycle after reset release.

Verification
REQ-035 Passthrough: offset 0, scale 1, shift 0, all lanes 5, prdy=1 -> cvtout lanes 5, pvld 3 cycles after transfer, counter 0.
REQ-036 Rounding: scale 1, shift 1; lanes 3, −3, 1, −1 -> 2, −1, 1, 0.
REQ-037 Offset/scale/saturation: offset 10, scale 2, shift 0; lanes 12, 1000, −1000, 73 -> 4, 127, −128, 126; counter=2.
REQ-038 Backpressure: stream 10 words, cvtout_prdy low cycles 4–8 -> mul2ocvt_prdy drops once 3 words are held, all 10 words exit in order and intact, output stable while stalled.
REQ-039 Counter edges: preload near max via saturating traffic -> counter holds 0xFFFFFFFF; sat_clr coincident with a 4-lane-saturated transfer -> counter 0.
REQ-040 Reset mid-stream with 3 words in flight -> no output after release, counter 0, next input emerges after 3 cycles.
